// File: rtl/multicycle_main_control.sv
// ============================================================================
//  Module   : multicycle_main_control
//  Brief    : Main control FSM for the multi-cycle CPU datapath, with memory
//             ready handshake, access timeout and illegal-opcode trap.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_main_control #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter logic [5:0]  OP_RTYPE    = 6'h00,
   parameter logic [5:0]  OP_LW       = 6'h23,
   parameter logic [5:0]  OP_SW       = 6'h2B,
   parameter logic [5:0]  OP_BEQ      = 6'h04,
   parameter logic [5:0]  OP_J        = 6'h02,
   parameter logic [5:0]  OP_ADDI     = 6'h08
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_en,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_source,
   output logic [2:0] alu_op,
   output logic [3:0] state,
   output logic       error
);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEM_ADDR = 4'd3,
      S_MEM_RD   = 4'd4,
      S_MEM_WB   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_R_EX     = 4'd7,
      S_R_WB     = 4'd8,
      S_BEQ      = 4'd9,
      S_JUMP     = 4'd10,
      S_I_EX     = 4'd11,
      S_I_WB     = 4'd12,
      S_ERROR    = 4'd15
   } stateT;

   typedef struct packed {
      logic       iord;
      logic       memRead;
      logic       memWrite;
      logic       regDst;
      logic       memToReg;
      logic       regWrite;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] pcSource;
      logic [2:0] aluOp;
      logic       error;
   } ctrlT;

   localparam logic [7:0] c_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   stateT      r_state;
   stateT      w_nextState;
   ctrlT       r_ctrl;
   logic [7:0] r_waitCnt;
   logic       w_isWait;
   logic       w_timeout;

   function automatic ctrlT decodeCtrl(input stateT s);
      ctrlT d;
      d = '0;
      case (s)
         S_FETCH:    begin d.memRead = 1'b1; d.aluSrcB = 2'b01; d.aluOp = 3'b001; end
         S_DECODE:   begin d.aluSrcB = 2'b11; d.aluOp = 3'b001; end
         S_MEM_ADDR: begin d.aluSrcA = 1'b1; d.aluSrcB = 2'b10; d.aluOp = 3'b001; end
         S_MEM_RD:   begin d.memRead = 1'b1; d.iord = 1'b1; end
         S_MEM_WB:   begin d.regWrite = 1'b1; d.memToReg = 1'b1; end
         S_MEM_WR:   begin d.memWrite = 1'b1; d.iord = 1'b1; end
         S_R_EX:     begin d.aluSrcA = 1'b1; d.aluOp = 3'b000; end
         S_R_WB:     begin d.regWrite = 1'b1; d.regDst = 1'b1; end
         S_BEQ:      begin d.aluSrcA = 1'b1; d.aluOp = 3'b010; d.pcSource = 2'b01; end
         S_JUMP:     d.pcSource = 2'b10;
         S_I_EX:     begin d.aluSrcA = 1'b1; d.aluSrcB = 2'b10; d.aluOp = 3'b001; end
         S_I_WB:     d.regWrite = 1'b1;
         S_ERROR:    d.error = 1'b1;
         default:    d = '0;
      endcase
      return d;
   endfunction

   assign w_isWait  = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
   // mem_ready on the last allowed cycle still completes the access
   assign w_timeout = w_isWait && !mem_ready && (r_waitCnt == c_WAIT_LAST);

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE:     w_nextState = S_FETCH;
         S_FETCH:    if (mem_ready) w_nextState = S_DECODE;
         S_DECODE: begin
            if (opcode == OP_LW || opcode == OP_SW) w_nextState = S_MEM_ADDR;
            else if (opcode == OP_RTYPE)            w_nextState = S_R_EX;
            else if (opcode == OP_BEQ)              w_nextState = S_BEQ;
            else if (opcode == OP_J)                w_nextState = S_JUMP;
            else if (opcode == OP_ADDI)             w_nextState = S_I_EX;
            else                                    w_nextState = S_ERROR;
         end
         S_MEM_ADDR: w_nextState = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   if (mem_ready) w_nextState = S_MEM_WB;
         S_MEM_WB:   w_nextState = S_FETCH;
         S_MEM_WR:   if (mem_ready) w_nextState = S_FETCH;
         S_R_EX:     w_nextState = S_R_WB;
         S_R_WB:     w_nextState = S_FETCH;
         S_BEQ:      w_nextState = S_FETCH;
         S_JUMP:     w_nextState = S_FETCH;
         S_I_EX:     w_nextState = S_I_WB;
         S_I_WB:     w_nextState = S_FETCH;
         S_ERROR:    w_nextState = S_ERROR;
         default:    w_nextState = S_ERROR;
      endcase
      if (w_timeout) w_nextState = S_ERROR;
   end

   // Moore outputs are registered from the next state so they line up with r_state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_ctrl    <= '0;
         r_waitCnt <= '0;
      end else begin
         r_state <= w_nextState;
         r_ctrl  <= decodeCtrl(w_nextState);
         if (w_nextState != r_state)
            r_waitCnt <= '0;
         else if (w_isWait && !mem_ready)
            r_waitCnt <= r_waitCnt + 8'd1;
      end
   end

   assign pc_en    = ((r_state == S_FETCH) && mem_ready) ||
                     ((r_state == S_BEQ) && zero) ||
                     (r_state == S_JUMP);
   assign ir_write = (r_state == S_FETCH) && mem_ready;

   assign iord       = r_ctrl.iord;
   assign mem_read   = r_ctrl.memRead;
   assign mem_write  = r_ctrl.memWrite;
   assign reg_dst    = r_ctrl.regDst;
   assign mem_to_reg = r_ctrl.memToReg;
   assign reg_write  = r_ctrl.regWrite;
   assign alu_src_a  = r_ctrl.aluSrcA;
   assign alu_src_b  = r_ctrl.aluSrcB;
   assign pc_source  = r_ctrl.pcSource;
   assign alu_op     = r_ctrl.aluOp;
   assign error      = r_ctrl.error;
   assign state      = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_main_control.sv
// ============================================================================
//  Module   : tb_multicycle_main_control
//  Brief    : Directed self-checking bench for multicycle_main_control.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multicycle_main_control;

   localparam int unsigned MEM_TIMEOUT = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic       zero;
   logic       memReady;
   logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst;
   logic       mem_to_reg, reg_write, alu_src_a, error;
   logic [1:0] alu_src_b, pc_source;
   logic [2:0] alu_op;
   logic [3:0] state;
   logic [16:0] ctl;

   int vecCount  = 0;
   int missCount = 0;

   multicycle_main_control #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(memReady),
      .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
      .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .pc_source(pc_source), .alu_op(alu_op), .state(state), .error(error)
   );

   always #5 clk = ~clk;

   // {pc_en, ir_write, iord, mem_read, mem_write, reg_dst, mem_to_reg,
   //  reg_write, alu_src_a, alu_src_b[1:0], pc_source[1:0], alu_op[2:0], error}
   assign ctl = {pc_en, ir_write, iord, mem_read, mem_write, reg_dst, mem_to_reg,
                 reg_write, alu_src_a, alu_src_b, pc_source, alu_op, error};

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecCount++;
      if (got !== exp) begin
         missCount++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n    = 1'b0;
      opcode   = 6'h00;
      zero     = 1'b0;
      memReady = 1'b1;

      // R-type: 0,1,2,7,8,1
      doReset();
      checkVal("reset_state", 32'(state), 32'd0);
      checkVal("reset_ctl", 32'(ctl), 32'h0);
      step(); checkVal("r_fetch", 32'(state), 32'd1);
      // FETCH with ready: pc_en ir_write mem_read alu_src_b=01 alu_op=001
      checkVal("fetch_ctl", 32'(ctl), 32'b1_1_0_1_0_0_0_0_0_01_00_001_0);
      step(); checkVal("r_decode", 32'(state), 32'd2);
      checkVal("decode_ctl", 32'(ctl), 32'b0_0_0_0_0_0_0_0_0_11_00_001_0);
      step(); checkVal("r_ex", 32'(state), 32'd7);
      checkVal("rex_ctl", 32'(ctl), 32'b0_0_0_0_0_0_0_0_1_00_00_000_0);
      step(); checkVal("r_wb", 32'(state), 32'd8);
      checkVal("rwb_ctl", 32'(ctl), 32'b0_0_0_0_0_1_0_1_0_00_00_000_0);
      step(); checkVal("r_back_fetch", 32'(state), 32'd1);

      // LW with 3 stall cycles in MEM_RD
      opcode = 6'h23;
      step(); checkVal("lw_decode", 32'(state), 32'd2);
      step(); checkVal("lw_addr", 32'(state), 32'd3);
      checkVal("memaddr_ctl", 32'(ctl), 32'b0_0_0_0_0_0_0_0_1_10_00_001_0);
      memReady = 1'b0;
      step(); checkVal("lw_rd0", 32'(state), 32'd4);
      checkVal("memrd_ctl", 32'(ctl), 32'b0_0_1_1_0_0_0_0_0_00_00_000_0);
      step(); checkVal("lw_rd1", 32'(state), 32'd4);
      step(); checkVal("lw_rd2", 32'(state), 32'd4);
      memReady = 1'b1;
      step(); checkVal("lw_wb", 32'(state), 32'd5);
      checkVal("memwb_ctl", 32'(ctl), 32'b0_0_0_0_0_0_1_1_0_00_00_000_0);
      step(); checkVal("lw_back_fetch", 32'(state), 32'd1);

      // SW, then async reset while stalled in MEM_WR
      opcode = 6'h2B;
      step(); step(); checkVal("sw_addr", 32'(state), 32'd3);
      memReady = 1'b0;
      step(); checkVal("sw_wr", 32'(state), 32'd6);
      checkVal("sw_memwrite", 32'(mem_write), 32'd1);
      checkVal("sw_iord", 32'(iord), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      checkVal("async_rst_state", 32'(state), 32'd0);
      checkVal("async_rst_memwrite", 32'(mem_write), 32'd0);
      @(negedge clk);
      rst_n    = 1'b1;
      memReady = 1'b1;

      // BEQ taken then not taken
      opcode = 6'h04;
      zero   = 1'b1;
      step(); step(); step(); checkVal("beq_t_state", 32'(state), 32'd9);
      checkVal("beq_t_ctl", 32'(ctl), 32'b1_0_0_0_0_0_0_0_1_00_01_010_0);
      step(); checkVal("beq_t_next", 32'(state), 32'd1);
      zero = 1'b0;
      step(); step(); checkVal("beq_nt_state", 32'(state), 32'd9);
      checkVal("beq_nt_pcen", 32'(pc_en), 32'd0);
      checkVal("beq_nt_pcsrc", 32'(pc_source), 32'd1);
      step(); checkVal("beq_nt_next", 32'(state), 32'd1);

      // ADDI
      opcode = 6'h08;
      step(); step(); checkVal("addi_ex", 32'(state), 32'd11);
      checkVal("iex_ctl", 32'(ctl), 32'b0_0_0_0_0_0_0_0_1_10_00_001_0);
      step(); checkVal("addi_wb", 32'(state), 32'd12);
      checkVal("iwb_ctl", 32'(ctl), 32'b0_0_0_0_0_0_0_1_0_00_00_000_0);
      step();

      // Jump, then enter FETCH with memory stalled until timeout
      opcode = 6'h02;
      step(); step(); checkVal("j_state", 32'(state), 32'd10);
      checkVal("j_ctl", 32'(ctl), 32'b1_0_0_0_0_0_0_0_0_00_10_000_0);
      memReady = 1'b0;
      step(); checkVal("to_fetch", 32'(state), 32'd1);
      for (int i = 0; i < int'(MEM_TIMEOUT) - 1; i++) step();
      checkVal("to_still_fetch", 32'(state), 32'd1);
      step(); checkVal("to_error", 32'(state), 32'd15);
      checkVal("to_error_ctl", 32'(ctl), 32'h1);
      memReady = 1'b1;
      step(); step(); checkVal("error_held", 32'(state), 32'd15);

      // Ready on exactly the last allowed cycle completes normally
      doReset();
      memReady = 1'b0;
      step(); checkVal("edge_fetch", 32'(state), 32'd1);
      for (int i = 0; i < int'(MEM_TIMEOUT) - 1; i++) step();
      memReady = 1'b1;
      checkVal("edge_last_fetch", 32'(state), 32'd1);
      step(); checkVal("edge_decode", 32'(state), 32'd2);

      // Illegal opcode
      doReset();
      opcode = 6'h3F;
      step(); step(); checkVal("ill_decode", 32'(state), 32'd2);
      step(); checkVal("ill_error", 32'(state), 32'd15);
      checkVal("ill_ctl", 32'(ctl), 32'h1);
      step(); step(); step();
      checkVal("ill_held", 32'(state), 32'd15);
      checkVal("ill_held_err", 32'(error), 32'd1);
      rst_n = 1'b0;
      #1 checkVal("ill_reset", 32'(state), 32'd0);
      checkVal("ill_reset_err", 32'(error), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule

`default_nettype wire
